// File: rtl/conv_output_limiter.sv
// -----------------------------------------------------------------------------
// conv_output_limiter
// Turns the 48-bit signed convolution result into 16-bit signed audio for the
// PDM speaker driver. The sample is arithmetic-shifted right by an adaptive
// amount, then saturated. The shift adapts with fast attack and slow release:
// - A loud output raises the shift by one step immediately.
// - After a hold period, a long run of quiet outputs lowers it by one step.
//
// Ports
//   audio_clk        audio clock
//   rst_in_n         asynchronous active-low reset
//   sample_valid_in  single-cycle strobe, sample_in valid
//   sample_in        signed convolution result (IN_WIDTH)
//   gain_freeze_in   1 = hold shift, FSM state and adaptation counters
//   clear_clip_in    single-cycle strobe, clears clip_sticky_out
//   sample_valid_out single-cycle strobe, sample_out updated (latency 2)
//   sample_out       signed limited audio (OUT_WIDTH), held between strobes
//   shift_out        current shift value
//   clip_out         single-cycle, with sample_valid_out when saturation hit
//   clip_sticky_out  set on any clip, held until clear_clip_in
// -----------------------------------------------------------------------------
module conv_output_limiter #(
    parameter int IN_WIDTH        = 48,
    parameter int OUT_WIDTH       = 16,
    parameter int INIT_SHIFT      = 12,
    parameter int MIN_SHIFT       = 0,
    parameter int MAX_SHIFT       = 32,
    parameter int HIGH_THRESH     = 24576,
    parameter int LOW_THRESH      = 4096,
    parameter int HOLD_SAMPLES    = 240,
    parameter int RELEASE_SAMPLES = 2400
) (
    input  logic                 audio_clk,
    input  logic                 rst_in_n,
    input  logic                 sample_valid_in,
    input  logic [IN_WIDTH-1:0]  sample_in,
    input  logic                 gain_freeze_in,
    input  logic                 clear_clip_in,
    output logic                 sample_valid_out,
    output logic [OUT_WIDTH-1:0] sample_out,
    output logic [5:0]           shift_out,
    output logic                 clip_out,
    output logic                 clip_sticky_out
);

    localparam int HOLD_W  = $clog2(HOLD_SAMPLES + 1);
    localparam int QUIET_W = $clog2(RELEASE_SAMPLES + 1);
    localparam int MAG_W   = OUT_WIDTH + 1;

    // Saturation bounds, sign-extended to the full input width.
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [0:0] {TRACK = 1'b0, HOLD = 1'b1} state_t;

    logic signed [IN_WIDTH-1:0] s1_data_r;
    logic                       s1_valid_r;
    logic [OUT_WIDTH-1:0]       sample_r;
    logic                       valid_r;
    logic                       clip_r;
    logic                       sticky_r;
    logic [5:0]                 shift_r;
    state_t                     state_r;
    logic [HOLD_W-1:0]          hold_r;
    logic [QUIET_W-1:0]         quiet_r;

    logic [OUT_WIDTH-1:0]       sat_s;
    logic                       clip_s;
    logic [MAG_W-1:0]           ext_s;
    logic [MAG_W-1:0]           mag_s;
    logic                       loud_s;
    logic                       quiet_s;
    logic [5:0]                 shift_up_s;
    logic [5:0]                 shift_dn_s;
    logic [5:0]                 shift_nxt_s;
    state_t                     state_nxt_s;
    logic [HOLD_W-1:0]          hold_nxt_s;
    logic [QUIET_W-1:0]         quiet_nxt_s;

    // Stage 1: capture the shifted sample using the shift value current at acceptance.
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            s1_data_r  <= '0;
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= sample_valid_in;
            if (sample_valid_in) begin
                s1_data_r <= $signed(sample_in) >>> shift_r;
            end else begin
                s1_data_r <= s1_data_r;
            end
        end
    end

    // Saturate the stage-1 value and derive its magnitude for the gain decisions.
    always_comb begin
        sat_s  = s1_data_r[OUT_WIDTH-1:0];
        clip_s = 1'b0;
        if (s1_data_r > SAT_MAX) begin
            sat_s  = SAT_MAX[OUT_WIDTH-1:0];
            clip_s = 1'b1;
        end else if (s1_data_r < SAT_MIN) begin
            sat_s  = SAT_MIN[OUT_WIDTH-1:0];
            clip_s = 1'b1;
        end else begin
            sat_s  = s1_data_r[OUT_WIDTH-1:0];
            clip_s = 1'b0;
        end
        // One extra bit so that the most negative value maps to +2^(OUT_WIDTH-1).
        ext_s = {sat_s[OUT_WIDTH-1], sat_s};
        if (ext_s[MAG_W-1]) begin
            mag_s = ~ext_s + MAG_W'(1);
        end else begin
            mag_s = ext_s;
        end
        loud_s  = clip_s || (mag_s > MAG_W'(HIGH_THRESH));
        quiet_s = (mag_s < MAG_W'(LOW_THRESH));
    end

    // Gain FSM: next shift, state and counters for the sample leaving stage 1.
    always_comb begin
        shift_up_s  = (shift_r >= 6'(MAX_SHIFT)) ? shift_r : shift_r + 6'd1;
        shift_dn_s  = (shift_r <= 6'(MIN_SHIFT)) ? shift_r : shift_r - 6'd1;
        shift_nxt_s = shift_r;
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        quiet_nxt_s = quiet_r;
        if (s1_valid_r && !gain_freeze_in) begin
            case (state_r)
                TRACK: begin
                    if (loud_s) begin
                        shift_nxt_s = shift_up_s;
                        quiet_nxt_s = '0;
                        hold_nxt_s  = '0;
                        state_nxt_s = HOLD;
                    end else if (quiet_s) begin
                        if (quiet_r + QUIET_W'(1) == QUIET_W'(RELEASE_SAMPLES)) begin
                            shift_nxt_s = shift_dn_s;
                            quiet_nxt_s = '0;
                        end else begin
                            quiet_nxt_s = quiet_r + QUIET_W'(1);
                        end
                    end else begin
                        quiet_nxt_s = '0;
                    end
                end
                HOLD: begin
                    if (loud_s) begin
                        shift_nxt_s = shift_up_s;
                        hold_nxt_s  = '0;
                    end else if (hold_r + HOLD_W'(1) == HOLD_W'(HOLD_SAMPLES)) begin
                        hold_nxt_s  = '0;
                        quiet_nxt_s = '0;
                        state_nxt_s = TRACK;
                    end else begin
                        hold_nxt_s = hold_r + HOLD_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = TRACK;
                    hold_nxt_s  = '0;
                    quiet_nxt_s = '0;
                end
            endcase
        end else begin
            shift_nxt_s = shift_r;
        end
    end

    // Stage 2 output registers, gain state and sticky clip flag.
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sample_r <= '0;
            valid_r  <= 1'b0;
            clip_r   <= 1'b0;
            sticky_r <= 1'b0;
            shift_r  <= 6'(INIT_SHIFT);
            state_r  <= TRACK;
            hold_r   <= '0;
            quiet_r  <= '0;
        end else begin
            valid_r <= s1_valid_r;
            clip_r  <= s1_valid_r & clip_s;
            if (s1_valid_r) begin
                sample_r <= sat_s;
            end else begin
                sample_r <= sample_r;
            end
            // A clear arriving while clip_out is high loses to that clip.
            sticky_r <= (s1_valid_r & clip_s) | clip_r | (sticky_r & ~clear_clip_in);
            shift_r  <= shift_nxt_s;
            state_r  <= state_nxt_s;
            hold_r   <= hold_nxt_s;
            quiet_r  <= quiet_nxt_s;
        end
    end

    assign sample_valid_out = valid_r;
    assign sample_out       = sample_r;
    assign shift_out        = shift_r;
    assign clip_out         = clip_r;
    assign clip_sticky_out  = sticky_r;

endmodule

// File: tb/tb_conv_output_limiter.sv
// -----------------------------------------------------------------------------
// tb_conv_output_limiter
// Directed-vector bench for conv_output_limiter. Expected values are hand
// computed from the default parameters. Covered behaviour:
// - Latency and arithmetic shift.
// - Saturation and the sticky clip flag.
// - Attack, hold and release timing.
// - Breaking a quiet run with a mid-level sample.
// - Freeze.
// - Clamping at the maximum shift.
// - Reset while a sample is in flight.
// -----------------------------------------------------------------------------
module tb_conv_output_limiter;

    logic        audio_clk = 1'b0;
    logic        rst_in_n;
    logic        sample_valid_in;
    logic [47:0] sample_in;
    logic        gain_freeze_in;
    logic        clear_clip_in;
    logic        sample_valid_out;
    logic [15:0] sample_out;
    logic [5:0]  shift_out;
    logic        clip_out;
    logic        clip_sticky_out;

    int n_cmp = 0;
    int n_err = 0;

    conv_output_limiter dut (
        .audio_clk        (audio_clk),
        .rst_in_n         (rst_in_n),
        .sample_valid_in  (sample_valid_in),
        .sample_in        (sample_in),
        .gain_freeze_in   (gain_freeze_in),
        .clear_clip_in    (clear_clip_in),
        .sample_valid_out (sample_valid_out),
        .sample_out       (sample_out),
        .shift_out        (shift_out),
        .clip_out         (clip_out),
        .clip_sticky_out  (clip_sticky_out)
    );

    always #5 audio_clk = ~audio_clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Send one sample and check latency, output value, clip flag and resulting shift.
    task automatic send(input string tag, input logic [47:0] din, input logic [15:0] exp_out,
                        input logic exp_clip, input logic [5:0] exp_shift);
        int n;
        @(negedge audio_clk);
        sample_valid_in = 1'b1;
        sample_in       = din;
        @(negedge audio_clk);
        sample_valid_in = 1'b0;
        n = 0;
        while (!sample_valid_out && n < 8) begin
            @(negedge audio_clk);
            n++;
        end
        check_val({tag, "_lat"}, 64'(n), 64'd1);
        check_val({tag, "_out"}, 64'(sample_out), 64'(exp_out));
        check_val({tag, "_clip"}, 64'(clip_out), 64'(exp_clip));
        check_val({tag, "_shift"}, 64'(shift_out), 64'(exp_shift));
    endtask

    // Stream samples of one value at three-cycle spacing without per-sample checks.
    task automatic run_const(input int count, input logic [47:0] din);
        for (int i = 0; i < count; i++) begin
            @(negedge audio_clk);
            sample_valid_in = 1'b1;
            sample_in       = din;
            @(negedge audio_clk);
            sample_valid_in = 1'b0;
            @(negedge audio_clk);
        end
    endtask

    // One-cycle clear strobe on clip_sticky_out.
    task automatic pulse_clear();
        @(negedge audio_clk);
        clear_clip_in = 1'b1;
        @(negedge audio_clk);
        clear_clip_in = 1'b0;
    endtask

    initial begin
        int seen;
        logic [5:0] exp_sh;
        rst_in_n        = 1'b0;
        sample_valid_in = 1'b0;
        sample_in       = 48'd0;
        gain_freeze_in  = 1'b0;
        clear_clip_in   = 1'b0;
        repeat (3) @(negedge audio_clk);
        check_val("rst_out", 64'(sample_out), 64'd0);
        check_val("rst_valid", 64'(sample_valid_out), 64'd0);
        check_val("rst_clip", 64'(clip_out), 64'd0);
        check_val("rst_sticky", 64'(clip_sticky_out), 64'd0);
        check_val("rst_shift", 64'(shift_out), 64'd12);
        rst_in_n = 1'b1;

        // Basic shift, positive and negative, mid-level (no gain change).
        send("basic", 48'h0000_0123_4000, 16'h1234, 1'b0, 6'd12);
        send("neg", 48'hFFFF_FEDC_C000, 16'hEDCC, 1'b0, 6'd12);
        check_val("basic_sticky", 64'(clip_sticky_out), 64'd0);

        // Attack: positive clip, then exactly -32768 (loud, not clipped).
        send("atk_pos", 48'h0000_1000_0000, 16'h7FFF, 1'b1, 6'd13);
        check_val("atk_sticky", 64'(clip_sticky_out), 64'd1);
        send("atk_neg", 48'hFFFF_F000_0000, 16'h8000, 1'b0, 6'd14);
        check_val("atk_sticky2", 64'(clip_sticky_out), 64'd1);
        pulse_clear();
        check_val("clr_sticky", 64'(clip_sticky_out), 64'd0);

        // Hold of 240, then release after 2400 quiet samples.
        run_const(240, 48'd0);
        check_val("hold_shift", 64'(shift_out), 64'd14);
        run_const(2399, 48'd0);
        check_val("pre_rel_shift", 64'(shift_out), 64'd14);
        send("rel", 48'd0, 16'h0000, 1'b0, 6'd13);

        // Quiet run broken at 2399 by |out| = 10000: release needs a fresh 2400.
        run_const(2399, 48'd0);
        send("mid", 48'd81920000, 16'h2710, 1'b0, 6'd13);
        run_const(2399, 48'd0);
        check_val("brk_shift", 64'(shift_out), 64'd13);
        send("rel2", 48'd0, 16'h0000, 1'b0, 6'd12);

        // Freeze: output still clips, shift does not move.
        gain_freeze_in = 1'b1;
        send("frz1", 48'h0100_0000_0000, 16'h7FFF, 1'b1, 6'd12);
        check_val("frz_sticky", 64'(clip_sticky_out), 64'd1);
        send("frz2", 48'h0100_0000_0000, 16'h7FFF, 1'b1, 6'd12);
        gain_freeze_in = 1'b0;
        pulse_clear();
        check_val("frz_clr", 64'(clip_sticky_out), 64'd0);

        // Drive the shift to MAX_SHIFT and beyond. At shift 32 the input
        // 2^47-1 yields 32767 exactly, so no clip there.
        for (int i = 0; i < 22; i++) begin
            exp_sh = (13 + i > 32) ? 6'd32 : 6'(13 + i);
            send("max", 48'h7FFF_FFFF_FFFF, 16'h7FFF, (12 + i < 32) ? 1'b1 : 1'b0, exp_sh);
        end

        // Reset while a sample is between acceptance and output.
        @(negedge audio_clk);
        sample_valid_in = 1'b1;
        sample_in       = 48'h0000_0123_4000;
        @(negedge audio_clk);
        sample_valid_in = 1'b0;
        rst_in_n        = 1'b0;
        @(negedge audio_clk);
        rst_in_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (sample_valid_out) seen++;
            @(negedge audio_clk);
        end
        check_val("mrst_valid", 64'(seen), 64'd0);
        check_val("mrst_out", 64'(sample_out), 64'd0);
        check_val("mrst_shift", 64'(shift_out), 64'd12);
        check_val("mrst_clip", 64'(clip_out), 64'd0);
        check_val("mrst_sticky", 64'(clip_sticky_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
